// File: rtl/types_pkg.sv
// Shared types for the input conditioner: debounce FSM states, run-time
// parameters and the cleaned-level bundle read by the calibration scenario FSM.
package types_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        RISE_CHECK  = 2'd1,
        STABLE_HIGH = 2'd2,
        FALL_CHECK  = 2'd3
    } debounce_state_t;

    typedef struct packed {
        logic [15:0] DEBOUNCE_LEN;
    } parameters_t;

    typedef struct packed {
        logic start;
        logic fg_opto;
    } input_signals_t;

    localparam logic [15:0] GLITCH_MAX = 16'hFFFF;

    // A zero length would accept on the first sample; treat it as one.
    function automatic logic [15:0] effective_len(input logic [15:0] len);
        return (len == 16'd0) ? 16'd1 : len;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Signal bundle between the input conditioner and its environment.
// Level/pulse semantics only: no valid/ready handshake, every output is valid each cycle.
interface input_conditioner_if;
    import types_pkg::*;

    logic           start_raw;
    logic           fg_opto_raw;
    parameters_t    par;
    logic           clear_counts;
    input_signals_t out;
    logic           start_rise;
    logic           fg_rise;
    logic [31:0]    fg_count;
    logic [15:0]    glitch_count;

    modport master (
        output start_raw, fg_opto_raw, par, clear_counts,
        input  out, start_rise, fg_rise, fg_count, glitch_count
    );

    modport slave (
        input  start_raw, fg_opto_raw, par, clear_counts,
        output out, start_rise, fg_rise, fg_count, glitch_count
    );

endinterface

// File: rtl/input_debounce.sv
// One debounced channel: 2-flop synchronizer followed by a four-state
// debounce FSM whose clean/rise/glitch outputs are decoded from state and s2.
module input_debounce
    import types_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        raw,
    input  logic [15:0] len,
    output logic        clean,
    output logic        rise,
    output logic        glitch
);

    logic            s1;
    logic            s2;
    debounce_state_t state;
    debounce_state_t state_d;
    logic [15:0]     hold_cnt;
    logic [15:0]     hold_cnt_d;
    logic [15:0]     n_eff;

    assign n_eff = effective_len(len);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= STABLE_LOW;
            hold_cnt <= 16'd0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_cnt_d;
        end
    end

    // Outputs are decoded in the deciding cycle, so the accepted level and the
    // rise pulse appear together, one cycle ahead of the registered state.
    always_comb begin
        state_d    = state;
        hold_cnt_d = hold_cnt;
        clean      = 1'b0;
        rise       = 1'b0;
        glitch     = 1'b0;
        case (state)
            STABLE_LOW: begin
                if (s2) begin
                    state_d    = RISE_CHECK;
                    hold_cnt_d = 16'd1;
                end
            end
            RISE_CHECK: begin
                if (!s2) begin
                    state_d    = STABLE_LOW;
                    hold_cnt_d = 16'd0;
                    glitch     = 1'b1;
                end else if (hold_cnt >= n_eff) begin
                    state_d    = STABLE_HIGH;
                    hold_cnt_d = 16'd0;
                    clean      = 1'b1;
                    rise       = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt + 16'd1;
                end
            end
            STABLE_HIGH: begin
                clean = 1'b1;
                if (!s2) begin
                    state_d    = FALL_CHECK;
                    hold_cnt_d = 16'd1;
                end
            end
            FALL_CHECK: begin
                clean = 1'b1;
                if (s2) begin
                    state_d    = STABLE_HIGH;
                    hold_cnt_d = 16'd0;
                    glitch     = 1'b1;
                end else if (hold_cnt >= n_eff) begin
                    state_d    = STABLE_LOW;
                    hold_cnt_d = 16'd0;
                    clean      = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt + 16'd1;
                end
            end
            default: begin
                state_d    = STABLE_LOW;
                hold_cnt_d = 16'd0;
            end
        endcase
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions the front-panel start line and the frame-grabber opto line, and
// keeps the accepted-edge and rejected-pulse counters.
module input_conditioner
    import types_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input_conditioner_if.slave   bus
);

    logic        start_clean;
    logic        start_glitch;
    logic        fg_clean;
    logic        fg_glitch;
    logic [31:0] fg_count_q;
    logic [15:0] glitch_count_q;
    logic [1:0]  glitch_events;
    logic [16:0] glitch_sum;
    logic [15:0] glitch_next;

    input_debounce u_start (
        .clock  (clock),
        .reset  (reset),
        .raw    (bus.start_raw),
        .len    (bus.par.DEBOUNCE_LEN),
        .clean  (start_clean),
        .rise   (bus.start_rise),
        .glitch (start_glitch)
    );

    input_debounce u_fg (
        .clock  (clock),
        .reset  (reset),
        .raw    (bus.fg_opto_raw),
        .len    (bus.par.DEBOUNCE_LEN),
        .clean  (fg_clean),
        .rise   (bus.fg_rise),
        .glitch (fg_glitch)
    );

    // Both channels may reject a pulse in the same cycle; the extra carry bit
    // catches an add of two that crosses the saturation point.
    assign glitch_events = {1'b0, start_glitch} + {1'b0, fg_glitch};
    assign glitch_sum    = {1'b0, glitch_count_q} + {15'd0, glitch_events};
    assign glitch_next   = glitch_sum[16] ? GLITCH_MAX : glitch_sum[15:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fg_count_q     <= 32'd0;
            glitch_count_q <= 16'd0;
        end else if (bus.clear_counts) begin
            fg_count_q     <= 32'd0;
            glitch_count_q <= 16'd0;
        end else begin
            fg_count_q     <= fg_count_q + {31'd0, bus.fg_rise};
            glitch_count_q <= glitch_next;
        end
    end

    assign bus.out          = '{start: start_clean, fg_opto: fg_clean};
    assign bus.fg_count     = fg_count_q;
    assign bus.glitch_count = glitch_count_q;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clock  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low (0 = reset).
REQ-004 start_raw  input  1  asynchronous start line from the front panel.
REQ-005 fg_opto_raw  input  1  asynchronous frame-grabber opto line.
REQ-006 par  input  parameters_t  uses field DEBOUNCE_LEN [15:0].
REQ-007 clear_counts  input  1  synchronous clear of both counters.
REQ-008 out  output  input_signals_t  cleaned levels in fields start and fg_opto, consumed by the calibration scenario FSM.
REQ-009 start_rise  output  1  one-cycle pulse on each accepted start rising edge.
REQ-010 fg_rise  output  1  one-cycle pulse on each accepted fg_opto rising edge.
REQ-011 fg_count  output  32  accepted fg_opto rising edges, wraps modulo 2^32.
REQ-012 glitch_count  output  16  rejected pulses on both channels, saturating at 0xFFFF.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-014 Each channel SHALL run a debounce FSM with states STABLE_LOW, RISE_CHECK, STABLE_HIGH and FALL_CHECK, plus a 16-bit hold counter.
REQ-015 STABLE_LOW: if s2=1, go to RISE_CHECK with counter=1; otherwise hold.
REQ-016 RISE_CHECK: if s2=0, return to STABLE_LOW and emit a glitch event.
- Else if counter >= N, go to STABLE_HIGH, set clean=1 and assert the rise pulse for exactly that cycle.
- Else increment the counter.
REQ-017 STABLE_HIGH and FALL_CHECK SHALL mirror REQ-015/016 with the polarity inverted; an accepted fall SHALL produce no pulse.
REQ-018 N SHALL equal par.DEBOUNCE_LEN, and DEBOUNCE_LEN=0 SHALL be treated as N=1.
REQ-019 The >= compare SHALL let a mid-check reduction of DEBOUNCE_LEN terminate the check on the next edge.
REQ-020 Latency: with raw stable from edge k, clean and the rise pulse SHALL update at edge k+1+N (N=1 gives edge k+2).
REQ-021 A pulse shorter than N synchronized samples SHALL never change clean and SHALL increment glitch_count by 1.
REQ-022 fg_count SHALL increment on fg_rise and wrap from 0xFFFFFFFF to 0.
REQ-023 glitch_count SHALL add the number of glitch events in a cycle (0, 1 or 2) and clamp at 0xFFFF.
REQ-024 clear_counts=1 SHALL zero both counters at the next edge, overriding any same-cycle increment.
REQ-025 Channels SHALL be fully independent, so simultaneous events on both channels are each handled.

Reset
REQ-026 When reset=0, all outputs SHALL be 0 immediately, both FSMs SHALL be in STABLE_LOW, and the synchronizers and hold counters SHALL be 0.
REQ-027 If a raw input is already high when reset releases, it SHALL go through the full debounce and produce one rise pulse; no pulse SHALL appear during reset.
REQ-028 Reset asserted mid-check SHALL abort the check without counting a glitch.

Structure
REQ-029 types_pkg SHALL hold the debounce_state_t enum, the DEBOUNCE_LEN field of parameters_t, and the reused input_signals_t.
REQ-030 Each channel SHALL be an instance of sub-module input_debounce (ports: clock, reset, raw, len, clean, rise, glitch), instantiated twice.
REQ-031 The counters and saturation logic SHALL live in input_conditioner.

Verification
REQ-032 DEBOUNCE_LEN=4; start_raw 0->1 at edge 10 and held -> out.start=1 and start_rise=1 for exactly one cycle at edge 15; glitch_count=0.
REQ-033 DEBOUNCE_LEN=4; fg_opto_raw high for 3 cycles -> out.fg_opto stays 0, fg_count=0, glitch_count=1.
REQ-034 DEBOUNCE_LEN=0; fg_opto_raw toggles 1,0 every 5 cycles, 10 times -> fg_count=10, each fg_rise 2 edges after its raw edge.
REQ-035 Preload fg_count=0xFFFFFFFE with glitch_count at 0xFFFE; 2 valid fg edges plus 3 glitches, one cycle containing glitches on both channels -> fg_count=0 and glitch_count=0xFFFF; then clear_counts coincident with fg_rise -> both counters 0.
REQ-036 start_raw held 1 through reset release -> no pulse during reset, exactly one start_rise N+2 edges after release; reset dropped mid-RISE_CHECK -> outputs 0 at once, glitch_count unchanged.
